// File: rtl/yurutme_bellek_yazmaci_if.sv
// Execute -> memory register bus: incoming instruction, held entry toward memory,
// and the forwarding/stall query path back to execute.
interface yurutme_bellek_yazmaci_if #(
  parameter int VERI_W = 32,
  parameter int RD_W   = 5
);
  logic              giris_gecerli_i;
  logic              giris_hazir_o;
  logic [VERI_W-1:0] alu_sonuc_i;
  logic [RD_W-1:0]   rd_i;
  logic              yaz_en_i;
  logic              bellek_oku_i;
  logic              bellek_yaz_i;
  logic [2:0]        bellek_boyut_i;
  logic [VERI_W-1:0] bellek_veri_i;
  logic              temizle_i;
  logic              cikis_gecerli_o;
  logic              cikis_hazir_i;
  logic [VERI_W-1:0] cikis_sonuc_o;
  logic [RD_W-1:0]   cikis_rd_o;
  logic              cikis_yaz_en_o;
  logic              cikis_oku_o;
  logic              cikis_yaz_o;
  logic [2:0]        cikis_boyut_o;
  logic [VERI_W-1:0] cikis_veri_o;
  logic [RD_W-1:0]   sorgu_rs1_i;
  logic [RD_W-1:0]   sorgu_rs2_i;
  logic              ileri_rs1_gecerli_o;
  logic [VERI_W-1:0] ileri_rs1_veri_o;
  logic              ileri_rs2_gecerli_o;
  logic [VERI_W-1:0] ileri_rs2_veri_o;
  logic              bekle_o;

  modport slave (
    input  giris_gecerli_i, alu_sonuc_i, rd_i, yaz_en_i, bellek_oku_i, bellek_yaz_i,
           bellek_boyut_i, bellek_veri_i, temizle_i, cikis_hazir_i, sorgu_rs1_i, sorgu_rs2_i,
    output giris_hazir_o, cikis_gecerli_o, cikis_sonuc_o, cikis_rd_o, cikis_yaz_en_o,
           cikis_oku_o, cikis_yaz_o, cikis_boyut_o, cikis_veri_o,
           ileri_rs1_gecerli_o, ileri_rs1_veri_o, ileri_rs2_gecerli_o, ileri_rs2_veri_o, bekle_o
  );

  modport master (
    output giris_gecerli_i, alu_sonuc_i, rd_i, yaz_en_i, bellek_oku_i, bellek_yaz_i,
           bellek_boyut_i, bellek_veri_i, temizle_i, cikis_hazir_i, sorgu_rs1_i, sorgu_rs2_i,
    input  giris_hazir_o, cikis_gecerli_o, cikis_sonuc_o, cikis_rd_o, cikis_yaz_en_o,
           cikis_oku_o, cikis_yaz_o, cikis_boyut_o, cikis_veri_o,
           ileri_rs1_gecerli_o, ileri_rs1_veri_o, ileri_rs2_gecerli_o, ileri_rs2_veri_o, bekle_o
  );
endinterface

// File: rtl/yurutme_bellek_yazmaci.sv
// Execute-to-memory pipeline register: 2-entry skid buffer (ANA drives the outputs,
// SKID holds the younger entry) with operand forwarding and load-use stall detection.
module yurutme_bellek_yazmaci #(
  parameter int VERI_W = 32,
  parameter int RD_W   = 5
) (
  input logic                   clk_i,
  input logic                   rst_i,
  yurutme_bellek_yazmaci_if.slave bus
);

  typedef struct packed {
    logic [VERI_W-1:0] sonuc;
    logic [RD_W-1:0]   rd;
    logic              yaz_en;
    logic              oku;
    logic              yaz;
    logic [2:0]        boyut;
    logic [VERI_W-1:0] veri;
  } kayit_t;

  typedef struct packed {
    logic              isabet;
    logic              bekle;
    logic [VERI_W-1:0] veri;
  } ileri_t;

  typedef enum logic [1:0] {BOS, TEK, DOLU} durum_t;

  durum_t durum;
  logic   gecerli_r;
  logic   hazir_r;
  kayit_t ana;
  kayit_t skid;
  kayit_t gelen;
  logic   giris_al;
  logic   cikis_ver;
  ileri_t ileri_rs1;
  ileri_t ileri_rs2;

  // Writes to x0 are architecturally void, so the enable is dropped at capture.
  function automatic kayit_t yakala(input logic [VERI_W-1:0] sonuc, input logic [RD_W-1:0] rd,
                                    input logic yaz_en, input logic oku, input logic yaz,
                                    input logic [2:0] boyut, input logic [VERI_W-1:0] veri);
    kayit_t k;
    k.sonuc  = sonuc;
    k.rd     = rd;
    k.yaz_en = yaz_en & (rd != '0);
    k.oku    = oku;
    k.yaz    = yaz;
    k.boyut  = boyut;
    k.veri   = veri;
    return k;
  endfunction

  // Youngest matching writer decides: a load stalls, anything else forwards its result.
  function automatic ileri_t ileri_ara(input logic [RD_W-1:0] rs,
                                       input logic ana_v, input kayit_t a,
                                       input logic skid_v, input kayit_t s);
    ileri_t r;
    kayit_t e;
    logic   bulundu;
    r       = '0;
    e       = '0;
    bulundu = 1'b0;
    if (rs != '0) begin
      if (skid_v && s.yaz_en && (s.rd == rs)) begin
        e       = s;
        bulundu = 1'b1;
      end else if (ana_v && a.yaz_en && (a.rd == rs)) begin
        e       = a;
        bulundu = 1'b1;
      end
    end
    if (bulundu) begin
      r.isabet = ~e.oku;
      r.bekle  = e.oku;
      r.veri   = e.oku ? '0 : e.sonuc;
    end
    return r;
  endfunction

  assign gelen = yakala(bus.alu_sonuc_i, bus.rd_i, bus.yaz_en_i, bus.bellek_oku_i,
                        bus.bellek_yaz_i, bus.bellek_boyut_i, bus.bellek_veri_i);

  assign giris_al  = bus.giris_gecerli_i & hazir_r;
  assign cikis_ver = gecerli_r & bus.cikis_hazir_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum     <= BOS;
      gecerli_r <= 1'b0;
      hazir_r   <= 1'b1;
      ana       <= '0;
    end else if (bus.temizle_i) begin
      durum     <= BOS;
      gecerli_r <= 1'b0;
      hazir_r   <= 1'b1;
    end else begin
      case (durum)
        BOS: begin
          if (giris_al) begin
            ana       <= gelen;
            durum     <= TEK;
            gecerli_r <= 1'b1;
          end
        end
        TEK: begin
          if (giris_al && cikis_ver) begin
            ana <= gelen;
          end else if (giris_al) begin
            durum   <= DOLU;
            hazir_r <= 1'b0;
          end else if (cikis_ver) begin
            durum     <= BOS;
            gecerli_r <= 1'b0;
          end
        end
        DOLU: begin
          if (cikis_ver) begin
            ana     <= skid;
            durum   <= TEK;
            hazir_r <= 1'b1;
          end
        end
        default: begin
          durum     <= BOS;
          gecerli_r <= 1'b0;
          hazir_r   <= 1'b1;
        end
      endcase
    end
  end

  // SKID contents are only observed while in DOLU, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (!bus.temizle_i && (durum == TEK) && giris_al && !cikis_ver) begin
      skid <= gelen;
    end
  end

  assign ileri_rs1 = ileri_ara(bus.sorgu_rs1_i, durum != BOS, ana, durum == DOLU, skid);
  assign ileri_rs2 = ileri_ara(bus.sorgu_rs2_i, durum != BOS, ana, durum == DOLU, skid);

  assign bus.giris_hazir_o       = hazir_r;
  assign bus.cikis_gecerli_o     = gecerli_r;
  assign bus.cikis_sonuc_o       = ana.sonuc;
  assign bus.cikis_rd_o          = ana.rd;
  assign bus.cikis_yaz_en_o      = ana.yaz_en;
  assign bus.cikis_oku_o         = ana.oku;
  assign bus.cikis_yaz_o         = ana.yaz;
  assign bus.cikis_boyut_o       = ana.boyut;
  assign bus.cikis_veri_o        = ana.veri;
  assign bus.ileri_rs1_gecerli_o = ileri_rs1.isabet;
  assign bus.ileri_rs1_veri_o    = ileri_rs1.veri;
  assign bus.ileri_rs2_gecerli_o = ileri_rs2.isabet;
  assign bus.ileri_rs2_veri_o    = ileri_rs2.veri;
  assign bus.bekle_o             = ileri_rs1.bekle | ileri_rs2.bekle;

endmodule

// File: tb/tb_yurutme_bellek_yazmaci.sv
// Scoreboard bench: driver pushes accepted instructions into an in-flight queue, a monitor
// pops on each memory-side handshake and checks forwarding/stall against the queue contents.
module tb_yurutme_bellek_yazmaci;

  logic clk;
  logic rst;

  yurutme_bellek_yazmaci_if #(.VERI_W(32), .RD_W(5)) bus ();

  yurutme_bellek_yazmaci #(.VERI_W(32), .RD_W(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] sonuc;
    logic [4:0]  rd;
    logic        we;
    logic        ld;
    logic        st;
    logic [2:0]  sz;
    logic [31:0] vd;
  } ent_t;

  ent_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: scan in-flight entries youngest first; first writer of rs decides.
  task automatic model_fwd(input logic [4:0] rs, output logic hit, output logic [31:0] v,
                           output logic stall);
    logic found;
    hit = 1'b0; v = '0; stall = 1'b0; found = 1'b0;
    if (rs != 0) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (!found && sb[i].we && sb[i].rd == rs) begin
          found = 1'b1;
          if (sb[i].ld) stall = 1'b1;
          else begin
            hit = 1'b1;
            v   = sb[i].sonuc;
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    logic        h1, h2, s1, s2;
    logic [31:0] v1, v2;
    ent_t        e;
    #2;
    if (!rst) begin
      chk("giris_hazir", {31'b0, bus.giris_hazir_o}, {31'b0, sb.size() < 2});
      chk("cikis_gecerli", {31'b0, bus.cikis_gecerli_o}, {31'b0, sb.size() > 0});
      model_fwd(bus.sorgu_rs1_i, h1, v1, s1);
      model_fwd(bus.sorgu_rs2_i, h2, v2, s2);
      chk("ileri_rs1_gecerli", {31'b0, bus.ileri_rs1_gecerli_o}, {31'b0, h1});
      chk("ileri_rs1_veri", bus.ileri_rs1_veri_o, v1);
      chk("ileri_rs2_gecerli", {31'b0, bus.ileri_rs2_gecerli_o}, {31'b0, h2});
      chk("ileri_rs2_veri", bus.ileri_rs2_veri_o, v2);
      chk("bekle", {31'b0, bus.bekle_o}, {31'b0, s1 | s2});
      if (sb.size() > 0 && bus.cikis_hazir_i && !bus.temizle_i) begin
        e = sb.pop_front();
        chk("cikis_sonuc", bus.cikis_sonuc_o, e.sonuc);
        chk("cikis_rd", {27'b0, bus.cikis_rd_o}, {27'b0, e.rd});
        chk("cikis_ctl", {27'b0, bus.cikis_yaz_en_o, bus.cikis_oku_o, bus.cikis_yaz_o, bus.cikis_boyut_o},
            {27'b0, e.we, e.ld, e.st, e.sz});
        chk("cikis_veri", bus.cikis_veri_o, e.vd);
      end
    end
  end

  task automatic step(input logic gec, input logic [31:0] son, input logic [4:0] rd,
                      input logic we, input logic ld, input logic st, input logic [2:0] sz,
                      input logic [31:0] vd, input logic ch, input logic fl,
                      input logic [4:0] q1, input logic [4:0] q2);
    logic al;
    ent_t e;
    @(negedge clk);
    bus.giris_gecerli_i = gec;
    bus.alu_sonuc_i     = son;
    bus.rd_i            = rd;
    bus.yaz_en_i        = we;
    bus.bellek_oku_i    = ld;
    bus.bellek_yaz_i    = st;
    bus.bellek_boyut_i  = sz;
    bus.bellek_veri_i   = vd;
    bus.cikis_hazir_i   = ch;
    bus.temizle_i       = fl;
    bus.sorgu_rs1_i     = q1;
    bus.sorgu_rs2_i     = q2;
    al = gec && (sb.size() < 2);
    e.sonuc = son; e.rd = rd; e.we = we && (rd != 0); e.ld = ld; e.st = st; e.sz = sz; e.vd = vd;
    @(posedge clk);
    #1;
    if (fl) sb.delete();
    else if (al) sb.push_back(e);
  endtask

  task automatic idle(input logic ch, input logic [4:0] q1, input logic [4:0] q2);
    step(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, ch, 1'b0, q1, q2);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    bus.giris_gecerli_i = 1'b0;
    bus.temizle_i       = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("rst_cikis_gecerli", {31'b0, bus.cikis_gecerli_o}, 32'd0);
    chk("rst_giris_hazir", {31'b0, bus.giris_hazir_o}, 32'd1);
    chk("rst_cikis_sonuc", bus.cikis_sonuc_o, 32'd0);
    sb.delete();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.giris_gecerli_i = 0; bus.alu_sonuc_i = 0; bus.rd_i = 0; bus.yaz_en_i = 0;
    bus.bellek_oku_i = 0; bus.bellek_yaz_i = 0; bus.bellek_boyut_i = 0; bus.bellek_veri_i = 0;
    bus.cikis_hazir_i = 0; bus.temizle_i = 0; bus.sorgu_rs1_i = 0; bus.sorgu_rs2_i = 0;
    #3;
    chk("reset_cikis_gecerli", {31'b0, bus.cikis_gecerli_o}, 32'd0);
    chk("reset_giris_hazir", {31'b0, bus.giris_hazir_o}, 32'd1);
    chk("reset_cikis_data", bus.cikis_sonuc_o | bus.cikis_veri_o | {27'b0, bus.cikis_rd_o}, 32'd0);
    #1;
    rst = 1'b0;

    step(1, 32'h0000_1234, 5'd5, 1, 0, 0, 3'd2, 32'h0, 1, 0, 5'd5, 5'd0);
    idle(1, 5'd5, 5'd0);
    idle(1, 5'd0, 5'd0);

    step(1, 32'h11, 5'd1, 1, 0, 0, 3'd0, 32'h0, 0, 0, 5'd1, 5'd2);
    step(1, 32'h22, 5'd2, 1, 0, 0, 3'd0, 32'h0, 0, 0, 5'd1, 5'd2);
    step(1, 32'h33, 5'd3, 1, 0, 0, 3'd0, 32'h0, 0, 0, 5'd1, 5'd2);
    idle(1, 5'd1, 5'd2);
    idle(1, 5'd1, 5'd2);
    idle(1, 5'd0, 5'd0);

    step(1, 32'h55, 5'd0, 1, 0, 0, 3'd0, 32'h0, 0, 0, 5'd0, 5'd0);
    idle(1, 5'd0, 5'd0);

    step(1, 32'hAAAA, 5'd3, 1, 0, 0, 3'd0, 32'h0, 0, 0, 5'd3, 5'd3);
    step(1, 32'hBBBB, 5'd3, 1, 0, 0, 3'd0, 32'h0, 0, 0, 5'd3, 5'd3);
    idle(0, 5'd3, 5'd3);
    idle(1, 5'd3, 5'd3);
    idle(1, 5'd3, 5'd3);

    step(1, 32'h7070, 5'd7, 1, 1, 0, 3'd2, 32'h0, 0, 0, 5'd0, 5'd7);
    idle(0, 5'd0, 5'd7);
    idle(1, 5'd0, 5'd7);
    step(1, 32'h7171, 5'd7, 1, 0, 0, 3'd2, 32'h0, 0, 0, 5'd0, 5'd7);
    idle(0, 5'd0, 5'd7);
    idle(1, 5'd7, 5'd7);

    step(1, 32'h1, 5'd1, 1, 0, 0, 3'd0, 32'h0, 0, 0, 5'd1, 5'd0);
    step(1, 32'h2, 5'd2, 1, 0, 0, 3'd0, 32'h0, 0, 0, 5'd1, 5'd2);
    step(1, 32'h3, 5'd3, 1, 0, 1, 3'd0, 32'hDEAD, 1, 1, 5'd1, 5'd2);
    idle(1, 5'd1, 5'd3);

    step(1, 32'h4, 5'd4, 1, 0, 0, 3'd0, 32'h0, 0, 0, 5'd4, 5'd0);
    step(1, 32'h5, 5'd5, 1, 0, 0, 3'd0, 32'h0, 0, 0, 5'd4, 5'd5);
    mid_reset();
    idle(1, 5'd4, 5'd5);

    for (int n = 0; n < 800; n++) begin
      if (n == 400) mid_reset();
      step($urandom_range(0, 9) < 7, $urandom, 5'($urandom_range(0, 3)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 9) < 6,
           $urandom_range(0, 19) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    end
    idle(1, 5'd0, 5'd0);
    idle(1, 5'd0, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
